per_transmissor: RTL and testbench

Peripheral-side transmitter that returns 4-bit words from the peripheral to the CPU over a four-phase send/ack handshake; it is the peripheral-to-CPU counterpart of the CPU-to-peripheral data path. A local producer pushes words into an internal FIFO. A three-state FSM drains the FIFO one word per complete handshake. A counter records delivered words, and a sticky flag records words lost to overflow.

---
 rtl/per_transmissor.sv | 112 +++++++++++
 tb/tb_per_transmissor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/per_transmissor.sv
// Peripheral-to-CPU transmitter: producer FIFO drained by a three-state send/ack FSM.
// Optional feature macro: PER_TX_ACK_SYNC_EN adds a two-flop synchronizer on per_tx_ack.
module per_transmissor #(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          per_clock,
  input  logic                          per_reset,
  input  logic                          per_wr_en,
  input  logic [DATA_W-1:0]             per_wr_dados,
  output logic                          per_full,
  output logic                          per_vazio,
  output logic [$clog2(FIFO_DEPTH):0]   per_nivel,
  output logic                          per_overflow,
  output logic                          per_tx_send,
  output logic [DATA_W-1:0]             per_tx_dados,
  input  logic                          per_tx_ack,
  output logic [7:0]                    per_tx_enviados
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Handshake: per_tx_send high means per_tx_dados is valid and stable; the CPU
  // raises ack to accept, send drops, and the next word waits until ack drops.
  typedef enum logic [1:0] {OCIOSO = 2'd0, ENVIA = 2'd1, LIBERA = 2'd2} estado_t;
  estado_t estado, prox_estado;

  logic              ack_s;
  logic              pop, conta, push_ok;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;

`ifdef PER_TX_ACK_SYNC_EN
  logic [1:0] ack_sync;
  always_ff @(posedge per_clock or negedge per_reset) begin
    if (!per_reset) ack_sync <= 2'b00;
    else            ack_sync <= {ack_sync[0], per_tx_ack};
  end
  assign ack_s = ack_sync[1];
`else
  assign ack_s = per_tx_ack;
`endif

  assign per_full    = (count == CW'(FIFO_DEPTH));
  assign per_vazio   = (count == '0);
  assign per_nivel   = count;
  assign per_tx_send = (estado == ENVIA);

  // A push at full still fits when the FSM frees a slot on the same edge.
  assign push_ok = per_wr_en && (!per_full || pop);

  always_ff @(posedge per_clock or negedge per_reset) begin
    if (!per_reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      per_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (per_wr_en && !push_ok) per_overflow <= 1'b1;
    end
  end

  always_ff @(posedge per_clock) begin
    if (push_ok) mem[wr_ptr] <= per_wr_dados;
  end

  always_ff @(posedge per_clock or negedge per_reset) begin
    if (!per_reset) estado <= OCIOSO;
    else            estado <= prox_estado;
  end

  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO:  if (!per_vazio && !ack_s) prox_estado = ENVIA;
      ENVIA:   if (ack_s)                prox_estado = LIBERA;
      LIBERA:  if (!ack_s)               prox_estado = OCIOSO;
      default:                           prox_estado = OCIOSO;
    endcase
  end

  always_comb begin
    pop   = 1'b0;
    conta = 1'b0;
    case (estado)
      OCIOSO:  pop   = !per_vazio && !ack_s;
      ENVIA:   conta = ack_s;
      default: ;
    endcase
  end

  // per_tx_dados keeps the last word after the handshake; it is never zeroed by the FSM.
  always_ff @(posedge per_clock or negedge per_reset) begin
    if (!per_reset) begin
      per_tx_dados    <= '0;
      per_tx_enviados <= '0;
    end else begin
      if (pop)   per_tx_dados    <= mem[rd_ptr];
      if (conta) per_tx_enviados <= per_tx_enviados + 8'd1;
    end
  end

endmodule

// File: tb/tb_per_transmissor.sv
// Directed and randomized bench for per_transmissor (default build, no ack synchronizer).
module tb_per_transmissor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_d;
  logic       full, vazio, overflow, send, ack;
  logic [2:0] nivel;
  logic [3:0] dados;
  logic [7:0] enviados;

  logic [3:0] exp_q[$];
  int         exp_sent;
  int         n_checks = 0;
  int         n_fail   = 0;

  per_transmissor #(.DATA_W(4), .FIFO_DEPTH(4)) dut (
    .per_clock(clk), .per_reset(rst_n), .per_wr_en(wr_en), .per_wr_dados(wr_d),
    .per_full(full), .per_vazio(vazio), .per_nivel(nivel), .per_overflow(overflow),
    .per_tx_send(send), .per_tx_dados(dados), .per_tx_ack(ack),
    .per_tx_enviados(enviados)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_checks++;
    assert (obs === expd) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
    end
  endtask

  // Called at a negedge; the word is taken on the following posedge.
  task automatic push(input logic [3:0] d, input bit accepted);
    wr_en = 1'b1;
    wr_d  = d;
    if (accepted) exp_q.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic reset_mid_cycle();
    #1 rst_n = 1'b0;
    exp_q.delete();
    exp_sent = 0;
    ack = 1'b0;
    wr_en = 1'b0;
    #1;
  endtask

  // CPU side of one four-phase handshake, called at a negedge.
  task automatic handshake(input int d_ack, input int d_rel);
    int t;
    logic [3:0] d;
    t = 0;
    while (send !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("send_wait", send, 1);
    d = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bx;
    check("tx_dados", dados, d);
    repeat (d_ack) @(negedge clk);
    check("send_hold", send, 1);
    check("dados_hold", dados, d);
    ack = 1'b1;
    @(negedge clk);
    exp_sent++;
    check("send_fall", send, 0);
    check("enviados", enviados, exp_sent % 256);
    repeat (d_rel) @(negedge clk);
    check("no_resend", send, 0);
    ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_d = '0; ack = 1'b0; exp_sent = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_send", send, 0);
      check("idle_dados", dados, 0);
      check("idle_vazio", vazio, 1);
      check("idle_nivel", nivel, 0);
      check("idle_enviados", enviados, 0);
    end

    // Single word, exact cycle timing
    push(4'hA, 1'b1);
    check("a_nivel", nivel, 1);
    check("a_vazio", vazio, 0);
    check("a_send_early", send, 0);
    @(negedge clk);
    check("a_send", send, 1);
    check("a_dados", dados, exp_q.pop_front());
    check("a_nivel_popped", nivel, 0);
    ack = 1'b1;
    @(negedge clk);
    exp_sent++;
    check("a_send_fall", send, 0);
    check("a_enviados", enviados, exp_sent);
    ack = 1'b0;
    @(negedge clk);
    check("a_send_low", send, 0);
    check("a_dados_kept", dados, 4'hA);
    check("a_vazio_end", vazio, 1);

    // Reset in the middle of ENVIA with three words queued
    for (int i = 0; i < 4; i++) push(4'(4'h3 + i), 1'b1);
    check("r_send", send, 1);
    check("r_nivel", nivel, 3);
    reset_mid_cycle();
    check("r_send_async", send, 0);
    check("r_nivel_async", nivel, 0);
    check("r_vazio_async", vazio, 1);
    check("r_full_async", full, 0);
    check("r_dados_async", dados, 0);
    check("r_enviados_async", enviados, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Ack held high before the push stalls the block
    ack = 1'b1;
    push(4'h7, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("h_send_stalled", send, 0);
      check("h_nivel", nivel, 1);
      @(negedge clk);
    end
    ack = 1'b0;
    @(negedge clk);
    check("h_send", send, 1);
    check("h_dados", dados, exp_q.pop_front());
    ack = 1'b1;
    @(negedge clk);
    exp_sent++;
    check("h_enviados", enviados, exp_sent);
    ack = 1'b0;
    @(negedge clk);

    // Fill while stalled, then push and pop on the same edge at full
    ack = 1'b1;
    for (int i = 1; i <= 4; i++) push(4'(i), 1'b1);
    check("f_full", full, 1);
    check("f_nivel", nivel, 4);
    ack = 1'b0;
    push(4'h9, 1'b1);
    check("f_nivel_pushpop", nivel, 4);
    check("f_full_pushpop", full, 1);
    check("f_no_overflow", overflow, 0);
    check("f_send", send, 1);
    for (int i = 0; i < 5; i++) handshake(1, 0);
    check("f_vazio", vazio, 1);

    // Overflow: fifth push while stalled is dropped
    ack = 1'b1;
    for (int i = 1; i <= 4; i++) push(4'(i), 1'b1);
    check("o_full", full, 1);
    check("o_ovf_before", overflow, 0);
    push(4'h5, 1'b0);
    check("o_overflow", overflow, 1);
    check("o_nivel", nivel, 4);
    ack = 1'b0;
    for (int i = 0; i < 4; i++) handshake(1, 1);
    check("o_vazio", vazio, 1);
    check("o_ovf_sticky", overflow, 1);
    reset_mid_cycle();
    check("o_ovf_cleared", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 300 random words through a loopback CPU
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          int t;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          t = 0;
          while (full === 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
          end
          push(4'($urandom_range(0, 15)), 1'b1);
        end
      end
      begin
        for (int i = 0; i < 300; i++) handshake($urandom_range(0, 2), $urandom_range(0, 2));
      end
    join
    check("s_enviados", enviados, 44);
    check("s_overflow", overflow, 0);
    check("s_vazio", vazio, 1);
    check("s_send", send, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
